spi_cmd_fifo: RTL and testbench
===============================

SPI_CMD_FIFO -- requirements
Module: spi_cmd_fifo

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL expose parameter DEPTH, default 4: command slots (power of two, 2..16).
REQ-003 The block SHALL expose parameter MAX_ADDR, default 7'h04: highest accepted register address.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  one-cycle pulse marking a decoded SPI frame from the deserializer.
REQ-007 in_read_write  input  1  frame type: 1 = write, 0 = read.
REQ-008 in_addr  input  7  frame register address.
REQ-009 in_data  input  8  frame payload.
REQ-010 out_valid  output  1  head entry available to the register-file stage.
REQ-011 out_addr  output  7  head entry address.
REQ-012 out_data  output  8  head entry data.
REQ-013 out_ready  input  1  consumer accepts the head entry when high with out_valid.
REQ-014 clr_status  input  1  one-cycle pulse clearing overflow and drop_cnt.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 overflow  output  1  sticky: a valid write was lost because the FIFO was full.
REQ-017 drop_cnt  output  8  saturating count of discarded write frames.

Function
REQ-018 A push SHALL occur when in_valid=1, in_read_write=1, in_addr<=MAX_ADDR, and either count<DEPTH or a pop happens in the same cycle.
REQ-019 Frames with in_read_write=0 SHALL be ignored: no push, no drop_cnt change, no overflow change.
REQ-020 A write frame with in_addr>MAX_ADDR SHALL be discarded and SHALL increment drop_cnt; overflow SHALL be unchanged.
REQ-021 A legal write frame with count=DEPTH and no same-cycle pop SHALL be discarded, SHALL set overflow, and SHALL increment drop_cnt.
REQ-022 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-023 Read-out SHALL be first-word-fall-through: after a push into an empty FIFO at edge N, out_valid, out_addr and out_data SHALL be valid from edge N onward, so the consumer sees them in the next cycle.
REQ-024 out_addr and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 A push into an empty FIFO SHALL NOT be popped in the same cycle, because out_valid is 0 during that cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count SHALL distinguish full (DEPTH) from empty (0).
REQ-028 out_valid SHALL equal (count!=0).
REQ-029 drop_cnt SHALL saturate at 255.
REQ-030 clr_status SHALL zero overflow and drop_cnt on the next edge; a same-cycle drop SHALL win, leaving overflow=1 (if the drop was an overflow) and drop_cnt=1.
REQ-031 Entry contents SHALL NOT be otherwise modified after push.

Reset
REQ-032 While rst=1, the block SHALL hold: pointers=0, count=0, out_valid=0, overflow=0, drop_cnt=0.
REQ-033 While rst=1, out_addr and out_data SHALL read 0; storage contents need not be reset.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries immediately and asynchronously.
REQ-035 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-036 Package spi_cmd_pkg SHALL hold ADDR_W=7, DATA_W=8, register address constants 0x00..0x04 (out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty), and a packed command type {addr, data}.
REQ-037 Storage SHALL be a sub-module spi_cmd_fifo_mem (DEPTH x 15-bit, one write port, combinational read); pointer, count and status logic SHALL reside in spi_cmd_fifo.

Verification
REQ-038 The bench SHALL cover: reset, then push write addr 0x02 data 0xA5 -> out_valid=1 next cycle, out_addr=0x02, out_data=0xA5, count=1.
REQ-039 The bench SHALL cover: 5 legal writes with out_ready=0 and DEPTH=4 -> count=4, overflow=1, drop_cnt=1, head = first frame.
REQ-040 The bench SHALL cover: a write to addr 0x05, then a read frame to addr 0x00 -> count=0, drop_cnt=1 after the write and unchanged after the read, overflow=0.
REQ-041 The bench SHALL cover: FIFO full, push and pop in the same cycle -> count stays 4 and the popped and pushed entries keep order across a pointer wrap.
REQ-042 The bench SHALL cover: 300 invalid-address writes -> drop_cnt=255; then clr_status -> drop_cnt=0.
REQ-043 The bench SHALL cover: assert rst with 3 entries queued -> out_valid=0 and count=0 asynchronously; after release a new entry is output with correct data.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// ============================================================================
// Module   : spi_cmd_pkg
// Brief    : Shared widths, register map and command type for the SPI path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_cmd_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CMD_W  = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] c_REG_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] c_REG_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] c_REG_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] c_REG_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] c_REG_DUTY     = 7'h04;

  typedef enum logic {
    FRAME_READ  = 1'b0,
    FRAME_WRITE = 1'b1
  } frame_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_cmd_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] i_addr,
                                         input logic [ADDR_W-1:0] i_max);
    return (i_addr <= i_max);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_fifo_mem.sv
// ============================================================================
// Module   : spi_cmd_fifo_mem
// Brief    : DEPTH x command storage, one synchronous write port, async read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_fifo_mem
  import spi_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  spi_cmd_t                 i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output spi_cmd_t                 o_rdata
);

  // Storage is deliberately left unreset; the top masks the head while empty.
  spi_cmd_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/spi_cmd_fifo.sv
// ============================================================================
// Module   : spi_cmd_fifo
// Brief    : First-word-fall-through command FIFO between the SPI deserializer
//            and the register file, with address filtering and drop status.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_fifo
  import spi_cmd_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 7'h04
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_read_write,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  input  logic                   clr_status,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [7:0]         c_SAT   = 8'hFF;

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  logic     w_not_empty;
  logic     w_full;
  logic     w_wr_frame;
  logic     w_addr_ok;
  logic     w_pop;
  logic     w_push;
  logic     w_drop_addr;
  logic     w_drop_full;
  logic     w_drop;
  spi_cmd_t w_wcmd;
  spi_cmd_t w_head;

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == c_FULL);
  assign w_wr_frame  = in_valid && (in_read_write == FRAME_WRITE);
  assign w_addr_ok   = addr_in_range(in_addr, MAX_ADDR);

  // Pop depends only on registered occupancy, so a frame landing in an
  // empty FIFO can never be consumed in the cycle it arrives.
  assign w_pop       = w_not_empty && out_ready;
  assign w_push      = w_wr_frame && w_addr_ok && (!w_full || w_pop);
  assign w_drop_addr = w_wr_frame && !w_addr_ok;
  assign w_drop_full = w_wr_frame && w_addr_ok && w_full && !w_pop;
  assign w_drop      = w_drop_addr || w_drop_full;

  always_comb begin
    w_wcmd      = '0;
    w_wcmd.addr = in_addr;
    w_wcmd.data = in_data;
  end

  spi_cmd_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wcmd),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as clr_status takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop_full) begin
        r_overflow <= 1'b1;
      end else if (clr_status) begin
        r_overflow <= 1'b0;
      end

      if (w_drop) begin
        if (clr_status) begin
          r_drop_cnt <= 8'd1;
        end else if (r_drop_cnt != c_SAT) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end else if (clr_status) begin
        r_drop_cnt <= '0;
      end
    end
  end

  assign out_valid = w_not_empty;
  assign out_addr  = w_not_empty ? w_head.addr : '0;
  assign out_data  = w_not_empty ? w_head.data : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_fifo.sv
// ============================================================================
// Module   : tb_spi_cmd_fifo
// Brief    : Self-checking bench for spi_cmd_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_fifo;
  import spi_cmd_pkg::*;

  localparam int                DEPTH    = 4;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 7'h04;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_read_write;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic                   out_ready;
  logic                   clr_status;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [7:0]             drop_cnt;

  spi_cmd_fifo #(
    .DEPTH    (DEPTH),
    .MAX_ADDR (MAX_ADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_read_write (in_read_write),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .clr_status    (clr_status),
    .count         (count),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  spi_cmd_t m_q[$];
  logic     m_ovf;
  int       m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, "_count"}, 32'(count), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      check({tag, "_addr"}, 32'(out_addr), 32'(m_q[0].addr));
      check({tag, "_data"}, 32'(out_data), 32'(m_q[0].data));
    end
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_read_write = 1'b0;
    in_addr       = '0;
    in_data       = '0;
    out_ready     = 1'b0;
    clr_status    = 1'b0;
  endtask

  // One clock of stimulus; the model applies the textual FIFO rules at the edge.
  task automatic cycle(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic rdy, input logic clr,
                       input string tag);
    bit       pop;
    bit       wr;
    bit       legal;
    bit       drop;
    bit       drop_full;
    spi_cmd_t cmd;
    @(negedge clk);
    in_valid      = v;
    in_read_write = rw;
    in_addr       = a;
    in_data       = d;
    out_ready     = rdy;
    clr_status    = clr;
    @(posedge clk);
    pop       = (m_q.size() != 0) && rdy;
    wr        = v && rw;
    legal     = (a <= MAX_ADDR);
    drop_full = wr && legal && (m_q.size() == DEPTH) && !pop;
    drop      = (wr && !legal) || drop_full;
    if (pop) void'(m_q.pop_front());
    if (wr && legal && !drop_full) begin
      cmd.addr = a;
      cmd.data = d;
      m_q.push_back(cmd);
    end
    if (drop_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (drop) m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    else if (clr) m_drop = 0;
    #1;
    check_state(tag);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, "drain");
  endtask

  initial begin
    m_ovf  = 1'b0;
    m_drop = 0;
    idle_inputs();
    rst = 1'b1;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First push right after reset release, visible the following cycle.
    cycle(1'b1, 1'b1, 7'h02, 8'hA5, 1'b0, 1'b0, "push1");
    check("push1_k_valid", 32'(out_valid), 32'd1);
    check("push1_k_addr", 32'(out_addr), 32'h02);
    check("push1_k_data", 32'(out_data), 32'hA5);
    check("push1_k_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, "hold");
    cycle(1'b0, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, "pop1");

    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 7'(i % 5), 8'h10 + 8'(i), 1'b0, 1'b0, "fill");
    check("full_k_count", 32'(count), 32'd4);
    check("full_k_ovf", 32'(overflow), 32'd1);
    check("full_k_drop", 32'(drop_cnt), 32'd1);
    check("full_k_head", 32'(out_data), 32'h10);

    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 7'(i % 5), 8'hC0 + 8'(i), 1'b1, 1'b0, "fullpp");
    check("fullpp_k_count", 32'(count), 32'd4);
    drain();

    cycle(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, "clr1");
    cycle(1'b1, 1'b1, 7'h05, 8'h5A, 1'b0, 1'b0, "badaddr");
    check("badaddr_k_drop", 32'(drop_cnt), 32'd1);
    cycle(1'b1, 1'b0, 7'h00, 8'h77, 1'b0, 1'b0, "rdframe");
    check("rdframe_k_drop", 32'(drop_cnt), 32'd1);
    check("rdframe_k_count", 32'(count), 32'd0);
    check("rdframe_k_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 300; i++)
      cycle(1'b1, 1'b1, 7'($urandom_range(5, 127)), 8'($urandom), 1'b0, 1'b0, "sat");
    check("sat_k_drop", 32'(drop_cnt), 32'd255);
    cycle(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, "clr2");
    check("clr2_k_drop", 32'(drop_cnt), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 1'b1, 7'h01, 8'h30 + 8'(i), 1'b0, 1'b0, "fill2");
    cycle(1'b1, 1'b1, 7'h03, 8'hEE, 1'b0, 1'b1, "clrdrop");
    check("clrdrop_k_ovf", 32'(overflow), 32'd1);
    check("clrdrop_k_drop", 32'(drop_cnt), 32'd1);
    drain();

    for (int i = 0; i < 600; i++)
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, 7'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom % 2), ($urandom % 16) == 0, "rnd");

    drain();
    cycle(1'b1, 1'b1, 7'h06, 8'h00, 1'b0, 1'b0, "pre_dropa");
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 7'(i), 8'h40 + 8'(i), 1'b0, 1'b0, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_addr", 32'(out_addr), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    m_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b1, 7'h03, 8'h3C, 1'b0, 1'b0, "post_rst");
    check("post_rst_k_addr", 32'(out_addr), 32'h03);
    check("post_rst_k_data", 32'(out_data), 32'h3C);
    check("post_rst_k_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
